fifo_drain_ctrl: RTL and testbench

- Read-side consumer for the ASYNC_FIFO read port, running entirely in the R_CLK domain.
- Monitors EMPTY and issues single-cycle R_INC pops. The FIFO head (RD_DATA, first-word-fall-through, valid whenever EMPTY=0) is captured into a 2-entry output skid buffer.
- Presents captured words downstream on a valid/ready handshake.
- Supports enable and flush (discard) control.

---
 rtl/fifo_drain_ctrl.sv | 158 +++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: pops an async FIFO into a 2-entry skid buffer.
// Define DRAIN_STATS_EN to add saturating RD_CNT / DROP_CNT statistics outputs.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  EN,
    input  logic                  FLUSH,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  R_INC,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY
`ifdef DRAIN_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  RD_CNT,
    output logic [CNT_WIDTH-1:0]  DROP_CNT
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_head;
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_adv;
    logic                  w_inc;
    logic                  w_push;
    logic                  w_acc;
    logic                  w_tail;
    logic                  w_flush_entry;

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FLUSH overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        if (FLUSH) begin
            w_state_nxt = S_FLUSH;
        end else begin
            unique case (r_state)
                S_IDLE:  if (EN) w_state_nxt = S_RUN;
                S_RUN:   if (!EN) w_state_nxt = S_IDLE;
                S_FLUSH: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // pop decision uses only registered occupancy, never OUT_READY
    always_comb begin
        w_inc = 1'b0;
        unique case (r_state)
            S_RUN:   w_inc = !EMPTY && (r_occ != 2'd2);
            S_FLUSH: w_inc = !EMPTY;
            default: w_inc = 1'b0;
        endcase
        w_inc = w_inc && R_RST;
    end

    assign R_INC         = w_inc;
    assign OUT_VALID     = (r_occ != 2'd0);
    assign OUT_DATA      = r_buf[r_head];
    assign BUSY          = (r_state != S_IDLE) || (r_occ != 2'd0);
    assign w_push        = w_inc && (r_state == S_RUN);
    assign w_acc         = OUT_VALID && OUT_READY;
    assign w_tail        = r_head ^ r_occ[0];
    assign w_flush_entry = FLUSH && (r_state != S_FLUSH);

    always_comb begin
        w_occ_adv = r_occ;
        unique case ({w_push, w_acc})
            2'b10:   w_occ_adv = r_occ + 2'd1;
            2'b01:   w_occ_adv = r_occ - 2'd1;
            default: w_occ_adv = r_occ;
        endcase
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_head   <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[w_tail] <= RD_DATA;
            end
            if (w_flush_entry || (r_state == S_FLUSH)) begin
                r_occ <= 2'd0;
            end else begin
                r_occ <= w_occ_adv;
                if (w_acc) begin
                    r_head <= ~r_head;
                end
            end
        end
    end

`ifdef DRAIN_STATS_EN
    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic [1:0]           w_drop_add;
    logic [CNT_WIDTH:0]   w_drop_sum;

    // words lost at entry are whatever the buffer would have held after the edge
    always_comb begin
        w_drop_add = 2'd0;
        if (w_flush_entry) begin
            w_drop_add = w_occ_adv;
        end else if ((r_state == S_FLUSH) && w_inc) begin
            w_drop_add = 2'd1;
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt}
                      + {{(CNT_WIDTH-1){1'b0}}, w_drop_add};

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            r_rd_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_acc && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (w_drop_sum[CNT_WIDTH]) begin
                r_drop_cnt <= '1;
            end else begin
                r_drop_cnt <= w_drop_sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign RD_CNT   = r_rd_cnt;
    assign DROP_CNT = r_drop_cnt;
`else
    logic [CNT_WIDTH-1:0] w_cnt_unused;
    assign w_cnt_unused = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl with a queue-based FIFO model.
// Counter checks are compiled only when DRAIN_STATS_EN is defined.
module tb_fifo_drain_ctrl;

    typedef logic [7:0] w8_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic       empty;
    w8_t        rd_data;
    logic       r_inc;
    w8_t        out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef DRAIN_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    fifo_drain_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .R_CLK(clk),
        .R_RST(rst_n),
        .EN(en),
        .FLUSH(flush),
        .EMPTY(empty),
        .RD_DATA(rd_data),
        .R_INC(r_inc),
        .OUT_DATA(out_data),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .BUSY(busy)
`ifdef DRAIN_STATS_EN
        ,
        .RD_CNT(rd_cnt),
        .DROP_CNT(drop_cnt)
`endif
    );

    w8_t  fifo_q[$];
    w8_t  pop_q[$];
    w8_t  out_q[$];
    w8_t  sent_q[$];
    logic s_inc, s_valid, s_busy, s_rdy, s_empty;
    w8_t  s_data;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic drive_fifo();
        empty   = (fifo_q.size() == 0);
        rd_data = empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic load(input w8_t w);
        fifo_q.push_back(w);
        sent_q.push_back(w);
        drive_fifo();
    endtask

    task automatic clear_model();
        fifo_q.delete();
        pop_q.delete();
        out_q.delete();
        sent_q.delete();
        drive_fifo();
    endtask

    // one clock: sample mid-cycle, then apply the FIFO/sink effects of the edge
    task automatic tick();
        @(negedge clk);
        s_inc   = r_inc;
        s_valid = out_valid;
        s_data  = out_data;
        s_busy  = busy;
        s_rdy   = out_ready;
        s_empty = empty;
        @(posedge clk);
        #1;
        if (s_inc && fifo_q.size() > 0) pop_q.push_back(fifo_q.pop_front());
        if (s_valid && s_rdy) out_q.push_back(s_data);
        drive_fifo();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        clear_model();
        load(8'hA5);
        load(8'h3C);
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({r_inc, out_valid, busy, out_data} !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got inc=%b vld=%b busy=%b data=%h required all 0",
                         r_inc, out_valid, busy, out_data);
            end
`ifdef DRAIN_STATS_EN
            n_cmp++;
            if (rd_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_counters: got %h/%h required 0/0", rd_cnt, drop_cnt);
            end
`endif
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        n_cmp++;
        if (s_inc !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_inc: got %b required 0", s_inc);
        end
        tick();
        n_cmp++;
        if (s_inc !== 1'b1 || pop_q.size() != 1) begin
            n_bad++;
            $display("FAIL reset_first_pop: got inc=%b pops=%0d required 1/1", s_inc, pop_q.size());
        end
    endtask

    task automatic test_stream();
        logic inc_h [8];
        logic val_h [8];
        w8_t  dat_h [8];
        w8_t  exp_w [3];
        exp_w = '{8'hB9, 8'h64, 8'h3E};
        do_reset();
        foreach (exp_w[i]) load(exp_w[i]);
        en        = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            inc_h[i] = s_inc;
            val_h[i] = s_valid;
            dat_h[i] = s_data;
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (inc_h[i] !== (i >= 1 && i <= 3)) begin
                n_bad++;
                $display("FAIL stream_inc[%0d]: got %b required %b", i, inc_h[i], (i >= 1 && i <= 3));
            end
            n_cmp++;
            if (val_h[i] !== (i >= 2 && i <= 4)) begin
                n_bad++;
                $display("FAIL stream_valid[%0d]: got %b required %b", i, val_h[i], (i >= 2 && i <= 4));
            end
            if (i >= 2 && i <= 4) begin
                n_cmp++;
                if (dat_h[i] !== exp_w[i-2]) begin
                    n_bad++;
                    $display("FAIL stream_data[%0d]: got %h required %h", i, dat_h[i], exp_w[i-2]);
                end
            end
        end
`ifdef DRAIN_STATS_EN
        n_cmp++;
        if (rd_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL stream_rd_cnt: got %0d required 3", rd_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        w8_t exp_w [4];
        int  cnt;
        exp_w = '{8'h1D, 8'h48, 8'hBF, 8'h5C};
        do_reset();
        foreach (exp_w[i]) load(exp_w[i]);
        en        = 1'b1;
        out_ready = 1'b0;
        repeat (6) begin
            tick();
            if (s_valid) begin
                n_cmp++;
                if (s_data !== 8'h1D) begin
                    n_bad++;
                    $display("FAIL bp_head_hold: got %h required 1d", s_data);
                end
            end
        end
        #1;
        n_cmp++;
        if (pop_q.size() != 2) begin
            n_bad++;
            $display("FAIL bp_pop_count: got %0d required 2", pop_q.size());
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h1D || r_inc !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_stall: got vld=%b data=%h inc=%b required 1/1d/0",
                     out_valid, out_data, r_inc);
        end
        out_ready = 1'b1;
        cnt = 0;
        while (out_q.size() < 4 && cnt < 20) begin
            tick();
            cnt++;
        end
        n_cmp++;
        if (cnt != 4) begin
            n_bad++;
            $display("FAIL bp_restart_cycles: got %0d required 4", cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= out_q.size() || out_q[i] !== exp_w[i]) begin
                n_bad++;
                $display("FAIL bp_order[%0d]: got %h required %h", i,
                         (i < out_q.size()) ? out_q[i] : 8'hxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_flush();
        int seen_valid;
        do_reset();
        for (int i = 0; i < 7; i++) load(8'(8'h11 * (i + 1)));
        en        = 1'b1;
        out_ready = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (pop_q.size() != 2 || fifo_q.size() != 5) begin
            n_bad++;
            $display("FAIL flush_setup: got pops=%0d left=%0d required 2/5", pop_q.size(), fifo_q.size());
        end
        flush = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_valid_drop: got %b required 0", out_valid);
        end
        seen_valid = 0;
        repeat (7) begin
            tick();
            if (s_valid) seen_valid++;
        end
        n_cmp++;
        if (pop_q.size() != 7 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_pops: got pops=%0d empty=%b required 7/1", pop_q.size(), empty);
        end
        n_cmp++;
        if (seen_valid != 0 || out_q.size() != 0) begin
            n_bad++;
            $display("FAIL flush_no_output: got valid_cycles=%0d delivered=%0d required 0/0",
                     seen_valid, out_q.size());
        end
`ifdef DRAIN_STATS_EN
        n_cmp++;
        if (drop_cnt !== 16'd7) begin
            n_bad++;
            $display("FAIL flush_drop_cnt: got %0d required 7", drop_cnt);
        end
`endif
        flush = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_exit_idle: got busy=%b required 0", busy);
        end
        tick();
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_rerun: got busy=%b required 1", busy);
        end
    endtask

    task automatic test_en_drop();
        logic acc_h  [16];
        logic busy_h [16];
        int   last;
        do_reset();
        for (int i = 0; i < 8; i++) load(w8_t'($urandom));
        en        = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            acc_h[k]  = s_valid && s_rdy;
            busy_h[k] = s_busy;
            if (pop_q.size() == 2) en = 1'b0;
        end
        n_cmp++;
        if (pop_q.size() != 3 || fifo_q.size() != 5) begin
            n_bad++;
            $display("FAIL endrop_pops: got pops=%0d left=%0d required 3/5", pop_q.size(), fifo_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= out_q.size() || out_q[i] !== sent_q[i]) begin
                n_bad++;
                $display("FAIL endrop_data[%0d]: got %h required %h", i,
                         (i < out_q.size()) ? out_q[i] : 8'hxx, sent_q[i]);
            end
        end
        last = -1;
        for (int k = 0; k < 16; k++) if (acc_h[k]) last = k;
        n_cmp++;
        if (last < 0 || last > 14 || busy_h[last] !== 1'b1 || busy_h[last+1] !== 1'b0) begin
            n_bad++;
            $display("FAIL endrop_busy_fall: last accept cycle %0d, busy not 1 then 0 around it", last);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) load(w8_t'($urandom));
        en        = 1'b1;
        out_ready = 1'b0;
        repeat (3) tick();
        #2;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre_valid: got %b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || r_inc !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_outputs: got vld=%b inc=%b busy=%b required 0/0/0",
                     out_valid, r_inc, busy);
        end
`ifdef DRAIN_STATS_EN
        n_cmp++;
        if (rd_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL areset_counters: got %h/%h required 0/0", rd_cnt, drop_cnt);
        end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        int   prev_occ;
        int   cnt;
        logic last_hold;
        w8_t  last_data;
        do_reset();
        en        = 1'b1;
        last_hold = 1'b0;
        last_data = 8'h00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) load(w8_t'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) en = ~en;
            prev_occ = pop_q.size() - out_q.size();
            tick();
            n_cmp++;
            if (s_inc && s_empty) begin
                n_bad++;
                $display("FAIL rnd_pop_on_empty: cycle %0d", cyc);
            end
            n_cmp++;
            if (s_inc && prev_occ >= 2) begin
                n_bad++;
                $display("FAIL rnd_overfill: cycle %0d occ %0d", cyc, prev_occ);
            end
            n_cmp++;
            if (s_valid !== (prev_occ != 0)) begin
                n_bad++;
                $display("FAIL rnd_valid: cycle %0d got %b required %b", cyc, s_valid, prev_occ != 0);
            end
            if (last_hold) begin
                n_cmp++;
                if (s_data !== last_data) begin
                    n_bad++;
                    $display("FAIL rnd_head_stable: cycle %0d got %h required %h", cyc, s_data, last_data);
                end
            end
            last_hold = s_valid && !s_rdy;
            last_data = s_data;
        end
        en        = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        while (out_q.size() < sent_q.size() && cnt < 60) begin
            tick();
            cnt++;
        end
        n_cmp++;
        if (out_q.size() != sent_q.size()) begin
            n_bad++;
            $display("FAIL rnd_count: got %0d required %0d", out_q.size(), sent_q.size());
        end
        for (int i = 0; i < sent_q.size(); i++) begin
            n_cmp++;
            if (i >= out_q.size() || out_q[i] !== sent_q[i]) begin
                n_bad++;
                $display("FAIL rnd_order[%0d]: got %h required %h", i,
                         (i < out_q.size()) ? out_q[i] : 8'hxx, sent_q[i]);
            end
        end
`ifdef DRAIN_STATS_EN
        n_cmp++;
        if (rd_cnt !== 16'(out_q.size())) begin
            n_bad++;
            $display("FAIL rnd_rd_cnt: got %0d required %0d", rd_cnt, out_q.size());
        end
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        empty     = 1'b1;
        rd_data   = 8'h00;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
